// File: rtl/debounce_edge_detect.sv
// Debounce and edge detect for a single re-timed input bit.
// Produces a debounced level, a one-cycle rise strobe, a wrapping press
// counter and a busy flag while a candidate transition is being qualified.
// Optional feature macro: DEBOUNCE_FALL_PULSE_EN adds the FALL_PULSE port
// and its register (one-cycle strobe on accepted 1->0 transitions).
module debounce_edge_detect #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned COUNT_WIDTH     = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   D_SYNC,
    output logic                   LEVEL,
    output logic                   RISE_PULSE,
`ifdef DEBOUNCE_FALL_PULSE_EN
    output logic                   FALL_PULSE,
`endif
    output logic [COUNT_WIDTH-1:0] PRESS_COUNT,
    output logic                   BUSY
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW    = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic [COUNT_WIDTH-1:0] press_q, press_d;
    logic                   busy_q, busy_d;
`ifdef DEBOUNCE_FALL_PULSE_EN
    logic                   fall_q, fall_d;
`endif

    // Next-state, stability counter and output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        press_d = press_q;
`ifdef DEBOUNCE_FALL_PULSE_EN
        fall_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE_LOW: begin
                if (D_SYNC) begin
                    state_d = CHECK_HIGH;
                    cnt_d   = '0;
                end
            end
            CHECK_HIGH: begin
                if (!D_SYNC) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    press_d = press_q + COUNT_WIDTH'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HIGH: begin
                if (!D_SYNC) begin
                    state_d = CHECK_LOW;
                    cnt_d   = '0;
                end
            end
            CHECK_LOW: begin
                if (D_SYNC) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
                    fall_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
        // Busy mirrors the registered state: high only in the check states
        busy_d = (state_d == CHECK_HIGH) || (state_d == CHECK_LOW);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            press_q <= '0;
            busy_q  <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
            fall_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            press_q <= press_d;
            busy_q  <= busy_d;
`ifdef DEBOUNCE_FALL_PULSE_EN
            fall_q  <= fall_d;
`endif
        end
    end

    assign LEVEL       = level_q;
    assign RISE_PULSE  = rise_q;
    assign PRESS_COUNT = press_q;
    assign BUSY        = busy_q;
`ifdef DEBOUNCE_FALL_PULSE_EN
    assign FALL_PULSE  = fall_q;
`endif

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed bench for debounce_edge_detect with DEBOUNCE_CYCLES=4, COUNT_WIDTH=8.
module tb_debounce_edge_detect;

    logic       clk;
    logic       rst_n;
    logic       d_sync;
    logic       level;
    logic       rise_pulse;
    logic [7:0] press_count;
    logic       busy;
`ifdef DEBOUNCE_FALL_PULSE_EN
    logic       fall_pulse;
`endif

    int tests = 0;
    int fails = 0;

    debounce_edge_detect #(
        .DEBOUNCE_CYCLES(4),
        .COUNT_WIDTH    (8)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .D_SYNC     (d_sync),
        .LEVEL      (level),
        .RISE_PULSE (rise_pulse),
`ifdef DEBOUNCE_FALL_PULSE_EN
        .FALL_PULSE (fall_pulse),
`endif
        .PRESS_COUNT(press_count),
        .BUSY       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_cnt;
        int         rises;

        // Reset state, no clock edge required
        rst_n  = 1'b0;
        d_sync = 1'b0;
        #1;
        check("rst_level", level, 1'b0);
        check("rst_rise", rise_pulse, 1'b0);
        check("rst_count", press_count, 8'd0);
        check("rst_busy", busy, 1'b0);
`ifdef DEBOUNCE_FALL_PULSE_EN
        check("rst_fall", fall_pulse, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_level", level, 1'b0);
        check("idle_busy", busy, 1'b0);

        // Clean rise: accepted at the 4th edge after the first high sample
        d_sync = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick();
            check("rise_wait_busy", busy, 1'b1);
            check("rise_wait_level", level, 1'b0);
            check("rise_wait_pulse", rise_pulse, 1'b0);
        end
        tick();
        check("rise_level", level, 1'b1);
        check("rise_pulse", rise_pulse, 1'b1);
        check("rise_count", press_count, 8'd1);
        check("rise_busy", busy, 1'b0);
        tick();
        check("rise_pulse_clr", rise_pulse, 1'b0);
        check("rise_level_hold", level, 1'b1);

        // Aborted low check: two low samples then high again
        d_sync = 1'b0;
        tick();
        check("lowglitch_busy0", busy, 1'b1);
        tick();
        check("lowglitch_busy1", busy, 1'b1);
        d_sync = 1'b1;
        tick();
        check("lowglitch_busy_end", busy, 1'b0);
        check("lowglitch_level", level, 1'b1);
        tick();

        // Clean fall: level drops at the 4th edge after the first low sample
        d_sync = 1'b0;
        for (int e = 0; e < 4; e++) begin
            tick();
            check("fall_wait_level", level, 1'b1);
            check("fall_wait_busy", busy, 1'b1);
        end
        tick();
        check("fall_level", level, 1'b0);
        check("fall_busy", busy, 1'b0);
        check("fall_no_rise", rise_pulse, 1'b0);
`ifdef DEBOUNCE_FALL_PULSE_EN
        check("fall_pulse", fall_pulse, 1'b1);
`endif
        tick();
        check("fall_level_hold", level, 1'b0);
`ifdef DEBOUNCE_FALL_PULSE_EN
        check("fall_pulse_clr", fall_pulse, 1'b0);
`endif

        // Glitch: high for three samples only
        d_sync = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            check("glitch_rise", rise_pulse, 1'b0);
        end
        d_sync = 1'b0;
        tick();
        check("glitch_level", level, 1'b0);
        check("glitch_busy", busy, 1'b0);
        check("glitch_count", press_count, 8'd1);
        tick();

        // Reset in CHECK_HIGH with counter=2
        d_sync = 1'b1;
        tick();
        tick();
        tick();
        check("midrst_busy_pre", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_count", press_count, 8'd0);
        check("midrst_level", level, 1'b0);
        check("midrst_rise", rise_pulse, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick();
            check("midrst_wait_level", level, 1'b0);
        end
        tick();
        check("midrst_level_acc", level, 1'b1);
        check("midrst_rise_acc", rise_pulse, 1'b1);
        check("midrst_count_acc", press_count, 8'd1);
        d_sync = 1'b0;
        repeat (5) tick();
        check("midrst_level_back", level, 1'b0);

        // Wrap of the press counter
        exp_cnt = 8'd1;
        for (int p = 0; p < 255; p++) begin
            rises  = 0;
            d_sync = 1'b1;
            repeat (5) begin
                tick();
                if (rise_pulse === 1'b1) rises++;
            end
            d_sync = 1'b0;
            repeat (5) begin
                tick();
                if (rise_pulse === 1'b1) rises++;
            end
            exp_cnt = exp_cnt + 8'd1;
            check("wrap_rises", 32'(rises), 32'd1);
            check("wrap_count", press_count, exp_cnt);
            if (p == 253) check("wrap_count_255", press_count, 8'd255);
        end
        check("wrap_count_0", press_count, 8'd0);

        // Toggle every cycle: FSM bounces IDLE_LOW <-> CHECK_HIGH
        for (int i = 0; i < 100; i++) begin
            d_sync = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            check("toggle_busy", busy, d_sync);
            check("toggle_level", level, 1'b0);
            check("toggle_rise", rise_pulse, 1'b0);
        end
        check("toggle_count", press_count, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
